// File: rtl/fault_mon_pkg.sv
// Shared types and constants for the multi-channel fault monitor.
// Holds the channel state encoding, handy fp32 literals and the default parameter values.
package fault_mon_pkg;

  typedef enum logic [1:0] {
    ST_NORMAL   = 2'd0,
    ST_WARNING  = 2'd1,
    ST_FAULT    = 2'd2,
    ST_SHUTDOWN = 2'd3
  } ch_state_e;

  localparam logic [31:0] FP_5_0 = 32'h40A0_0000;
  localparam logic [31:0] FP_2_0 = 32'h4000_0000;
  localparam logic [31:0] FP_0_1 = 32'h3DCC_CCCD;

  localparam int DEF_NCH          = 4;
  localparam int DEF_WARN_CNT     = 3;
  localparam int DEF_SHDN_CNT     = 4;
  localparam int DEF_RECOV_CNT    = 8;
  localparam int DEF_AUTO_RECOVER = 0;

  function automatic int max3(input int a, input int b, input int c);
    int m;
    m = (a > b) ? a : b;
    return (m > c) ? m : c;
  endfunction

endpackage

// File: rtl/fp32_cmp.sv
// Combinational IEEE-754 single-precision compare of a against b.
// Signed zeros compare equal; any NaN operand gives unordered with gt=lt=0.
module fp32_cmp (
  input  logic [31:0] a,
  input  logic [31:0] b,
  output logic        gt,
  output logic        lt,
  output logic        unordered
);

  logic        a_nan;
  logic        b_nan;
  logic        both_zero;
  logic [31:0] key_a;
  logic [31:0] key_b;

  assign a_nan     = (&a[30:23]) && (|a[22:0]);
  assign b_nan     = (&b[30:23]) && (|b[22:0]);
  assign both_zero = (a[30:0] == 31'd0) && (b[30:0] == 31'd0);

  // Map sign-magnitude onto a monotonic unsigned key so one compare covers every sign case.
  assign key_a = a[31] ? ~a : {1'b1, a[30:0]};
  assign key_b = b[31] ? ~b : {1'b1, b[30:0]};

  assign unordered = a_nan || b_nan;
  assign gt        = !unordered && !both_zero && (key_a > key_b);
  assign lt        = !unordered && !both_zero && (key_a < key_b);

endmodule

// File: rtl/multi_fault_monitor.sv
// Per-channel fp32 window monitor with NORMAL/WARNING/FAULT/SHUTDOWN escalation,
// registered aggregate flags and first-shutdown channel capture.
//
// state       | meaning
// ------------+------------------------------------------------------------
// ST_NORMAL   | sample inside window, counters idle
// ST_WARNING  | abnormal run started, bad counts toward WARN_CNT
// ST_FAULT    | bad counts toward SHDN_CNT, good counts toward RECOV_CNT
// ST_SHUTDOWN | sticky; left on clear (or RECOV_CNT good samples if AUTO_RECOVER)
module multi_fault_monitor
  import fault_mon_pkg::*;
#(
  parameter int NCH          = DEF_NCH,
  parameter int WARN_CNT     = DEF_WARN_CNT,
  parameter int SHDN_CNT     = DEF_SHDN_CNT,
  parameter int RECOV_CNT    = DEF_RECOV_CNT,
  parameter int AUTO_RECOVER = DEF_AUTO_RECOVER
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     sample_valid,
  input  logic [32*NCH-1:0]        sample,
  input  logic [32*NCH-1:0]        thr_hi,
  input  logic [32*NCH-1:0]        thr_lo,
  input  logic [NCH-1:0]           ch_enable,
  input  logic                     clear,
  output logic                     warning,
  output logic                     fault,
  output logic                     shutdown,
  output logic [2*NCH-1:0]         ch_state,
  output logic [$clog2(NCH)-1:0]   first_ch,
  output logic                     first_valid
);

  localparam int FW = $clog2(NCH);
  localparam int CW = $clog2(max3(WARN_CNT, SHDN_CNT, RECOV_CNT) + 1);

  function automatic logic [CW-1:0] sat_inc(input logic [CW-1:0] v);
    return (&v) ? v : v + CW'(1);
  endfunction

  ch_state_e      st_q   [NCH];
  ch_state_e      st_d   [NCH];
  logic [CW-1:0]  bad_q  [NCH];
  logic [CW-1:0]  bad_d  [NCH];
  logic [CW-1:0]  good_q [NCH];
  logic [CW-1:0]  good_d [NCH];
  logic [NCH-1:0] abn;
  logic [NCH-1:0] ent;
  logic           warn_d, fault_d, shdn_d, fv_d;
  logic [FW-1:0]  first_d;

  for (genvar k = 0; k < NCH; k++) begin : g_cmp
    logic gt_hi, lt_hi, un_hi, gt_lo, lt_lo, un_lo;
    logic ok_hi, ok_lo;

    fp32_cmp u_cmp_hi (
      .a         (sample[32*k +: 32]),
      .b         (thr_hi[32*k +: 32]),
      .gt        (gt_hi),
      .lt        (lt_hi),
      .unordered (un_hi)
    );

    fp32_cmp u_cmp_lo (
      .a         (sample[32*k +: 32]),
      .b         (thr_lo[32*k +: 32]),
      .gt        (gt_lo),
      .lt        (lt_lo),
      .unordered (un_lo)
    );

    // At-limit samples are in range; unordered (NaN) never is.
    assign ok_hi  = lt_hi || !(gt_hi || lt_hi || un_hi);
    assign ok_lo  = gt_lo || !(gt_lo || lt_lo || un_lo);
    assign abn[k] = !(ok_hi && ok_lo);
  end

  always_comb begin
    ent = '0;
    for (int k = 0; k < NCH; k++) begin
      st_d[k]   = st_q[k];
      bad_d[k]  = bad_q[k];
      good_d[k] = good_q[k];
      if (!ch_enable[k]) begin
        st_d[k]   = ST_NORMAL;
        bad_d[k]  = '0;
        good_d[k] = '0;
      end else if (clear && (st_q[k] == ST_SHUTDOWN)) begin
        st_d[k]   = ST_NORMAL;
        bad_d[k]  = '0;
        good_d[k] = '0;
      end else if (sample_valid) begin
        case (st_q[k])
          ST_NORMAL: begin
            if (abn[k]) begin
              st_d[k]  = ST_WARNING;
              bad_d[k] = CW'(1);
            end
          end
          ST_WARNING: begin
            if (!abn[k]) begin
              st_d[k]  = ST_NORMAL;
              bad_d[k] = '0;
            end else if (sat_inc(bad_q[k]) >= CW'(WARN_CNT)) begin
              st_d[k]   = ST_FAULT;
              bad_d[k]  = '0;
              good_d[k] = '0;
            end else begin
              bad_d[k] = sat_inc(bad_q[k]);
            end
          end
          ST_FAULT: begin
            if (abn[k]) begin
              good_d[k] = '0;
              if (sat_inc(bad_q[k]) >= CW'(SHDN_CNT)) begin
                st_d[k]  = ST_SHUTDOWN;
                bad_d[k] = '0;
              end else begin
                bad_d[k] = sat_inc(bad_q[k]);
              end
            end else begin
              bad_d[k] = '0;
              if (sat_inc(good_q[k]) >= CW'(RECOV_CNT)) begin
                st_d[k]   = ST_NORMAL;
                good_d[k] = '0;
              end else begin
                good_d[k] = sat_inc(good_q[k]);
              end
            end
          end
          ST_SHUTDOWN: begin
            if (AUTO_RECOVER != 0) begin
              if (abn[k]) begin
                good_d[k] = '0;
              end else if (sat_inc(good_q[k]) >= CW'(RECOV_CNT)) begin
                st_d[k]   = ST_NORMAL;
                bad_d[k]  = '0;
                good_d[k] = '0;
              end else begin
                good_d[k] = sat_inc(good_q[k]);
              end
            end
          end
          default: st_d[k] = ST_NORMAL;
        endcase
      end
      ent[k] = (st_d[k] == ST_SHUTDOWN) && (st_q[k] != ST_SHUTDOWN);
    end
  end

  always_comb begin
    warn_d  = 1'b0;
    fault_d = 1'b0;
    shdn_d  = 1'b0;
    for (int k = 0; k < NCH; k++) begin
      warn_d  = warn_d  || (st_d[k] == ST_WARNING);
      fault_d = fault_d || (st_d[k] == ST_FAULT);
      shdn_d  = shdn_d  || (st_d[k] == ST_SHUTDOWN);
    end
  end

  // A clear re-arms capture, so an entry on the clearing edge is recorded fresh.
  always_comb begin
    first_d = first_ch;
    fv_d    = first_valid;
    if (clear) begin
      first_d = '0;
      fv_d    = 1'b0;
    end
    if (!fv_d && (|ent)) begin
      fv_d = 1'b1;
      for (int k = NCH - 1; k >= 0; k--) begin
        if (ent[k]) first_d = FW'(k);
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int k = 0; k < NCH; k++) begin
        st_q[k]   <= ST_NORMAL;
        bad_q[k]  <= '0;
        good_q[k] <= '0;
      end
      warning     <= 1'b0;
      fault       <= 1'b0;
      shutdown    <= 1'b0;
      first_ch    <= '0;
      first_valid <= 1'b0;
    end else begin
      for (int k = 0; k < NCH; k++) begin
        st_q[k]   <= st_d[k];
        bad_q[k]  <= bad_d[k];
        good_q[k] <= good_d[k];
      end
      warning     <= warn_d;
      fault       <= fault_d;
      shutdown    <= shdn_d;
      first_ch    <= first_d;
      first_valid <= fv_d;
    end
  end

  always_comb begin
    ch_state = '0;
    for (int k = 0; k < NCH; k++) ch_state[2*k +: 2] = st_q[k];
  end

endmodule

// File: tb/tb_multi_fault_monitor.sv
// Self-checking bench for multi_fault_monitor: directed scenarios plus randomized
// traffic compared against a real-arithmetic reference model of the channel rules.
module tb_multi_fault_monitor;
  import fault_mon_pkg::*;

  localparam int NCH   = 4;
  localparam int WARN  = 3;
  localparam int SHDN  = 4;
  localparam int RECOV = 8;

  logic                clk = 1'b0;
  logic                rst;
  logic                sample_valid;
  logic [32*NCH-1:0]   sample, thr_hi, thr_lo;
  logic [NCH-1:0]      ch_enable;
  logic                clear;
  logic                warning, fault, shutdown;
  logic [2*NCH-1:0]    ch_state;
  logic [1:0]          first_ch;
  logic                first_valid;

  int total = 0;
  int bad   = 0;

  int m_st   [NCH];
  int m_bad  [NCH];
  int m_good [NCH];
  int m_first;
  bit m_fv;

  multi_fault_monitor #(
    .NCH(NCH), .WARN_CNT(WARN), .SHDN_CNT(SHDN), .RECOV_CNT(RECOV), .AUTO_RECOVER(0)
  ) dut (
    .clk(clk), .rst(rst), .sample_valid(sample_valid), .sample(sample),
    .thr_hi(thr_hi), .thr_lo(thr_lo), .ch_enable(ch_enable), .clear(clear),
    .warning(warning), .fault(fault), .shutdown(shutdown), .ch_state(ch_state),
    .first_ch(first_ch), .first_valid(first_valid)
  );

  always #5 clk = ~clk;

  initial begin
    #1000000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  // ---------------- reference model ----------------
  function automatic bit fp_nan(input logic [31:0] b);
    return (b[30:23] == 8'hFF) && (b[22:0] != 23'd0);
  endfunction

  function automatic real fp_val(input logic [31:0] b);
    int  e;
    real m, v;
    e = int'(b[30:23]);
    m = real'(int'(b[22:0]));
    if (e == 0)        v = m * (2.0 ** (-149.0));
    else if (e == 255) v = 1.0e300;
    else               v = (1.0 + m / 8388608.0) * (2.0 ** real'(e - 127));
    return b[31] ? -v : v;
  endfunction

  function automatic bit is_abn(input int k);
    logic [31:0] s, h, l;
    s = sample[32*k +: 32];
    h = thr_hi[32*k +: 32];
    l = thr_lo[32*k +: 32];
    return fp_nan(s) || (fp_val(s) > fp_val(h)) || (fp_val(s) < fp_val(l));
  endfunction

  function automatic void model_reset();
    for (int k = 0; k < NCH; k++) begin
      m_st[k] = 0; m_bad[k] = 0; m_good[k] = 0;
    end
    m_first = 0;
    m_fv    = 0;
  endfunction

  function automatic void model_update();
    int prev [NCH];
    bit a, found;
    for (int k = 0; k < NCH; k++) prev[k] = m_st[k];
    for (int k = 0; k < NCH; k++) begin
      a = is_abn(k);
      if (!ch_enable[k] || (clear && m_st[k] == 3)) begin
        m_st[k] = 0; m_bad[k] = 0; m_good[k] = 0;
      end else if (sample_valid) begin
        if (m_st[k] == 0) begin
          if (a) begin m_st[k] = 1; m_bad[k] = 1; end
        end else if (m_st[k] == 1) begin
          if (!a) begin m_st[k] = 0; m_bad[k] = 0; end
          else begin
            m_bad[k]++;
            if (m_bad[k] >= WARN) begin m_st[k] = 2; m_bad[k] = 0; m_good[k] = 0; end
          end
        end else if (m_st[k] == 2) begin
          if (a) begin
            m_good[k] = 0; m_bad[k]++;
            if (m_bad[k] >= SHDN) begin m_st[k] = 3; m_bad[k] = 0; end
          end else begin
            m_bad[k] = 0; m_good[k]++;
            if (m_good[k] >= RECOV) begin m_st[k] = 0; m_good[k] = 0; end
          end
        end
      end
    end
    if (clear) begin m_fv = 0; m_first = 0; end
    if (!m_fv) begin
      found = 0;
      for (int k = 0; k < NCH; k++) begin
        if (!found && m_st[k] == 3 && prev[k] != 3) begin
          m_first = k; m_fv = 1; found = 1;
        end
      end
    end
  endfunction

  function automatic logic [2*NCH-1:0] m_chs();
    logic [2*NCH-1:0] r;
    for (int k = 0; k < NCH; k++) r[2*k +: 2] = 2'(m_st[k]);
    return r;
  endfunction

  function automatic logic m_any(input int s);
    logic r;
    r = 1'b0;
    for (int k = 0; k < NCH; k++) if (m_st[k] == s) r = 1'b1;
    return r;
  endfunction

  // ---------------- stimulus helpers ----------------
  task automatic set_defaults();
    sample_valid = 1'b0;
    clear        = 1'b0;
    ch_enable    = '1;
    for (int k = 0; k < NCH; k++) begin
      sample[32*k +: 32] = FP_2_0;
      thr_hi[32*k +: 32] = FP_5_0;
      thr_lo[32*k +: 32] = FP_0_1;
    end
  endtask

  task automatic step();
    model_update();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    model_reset();
    @(posedge clk);
    #1;
    rst = 1'b0;
  endtask

  function automatic logic [31:0] rnd_abn();
    case ($urandom_range(0, 5))
      0: return 32'h40A0_0001;
      1: return 32'hBF80_0000;
      2: return 32'h7FC0_0000 | 32'($urandom_range(0, 1023));
      3: return 32'h8000_0000;
      4: return 32'hFF80_0000;
      default: return $urandom;
    endcase
  endfunction

  function automatic logic [31:0] rnd_norm();
    case ($urandom_range(0, 4))
      0: return FP_2_0;
      1: return FP_5_0;
      2: return FP_0_1;
      3: return 32'h3F80_0000;
      default: return 32'h4040_0000 + 32'($urandom_range(0, 65535));
    endcase
  endfunction

  // ---------------- tests ----------------
  task automatic test_reset();
    set_defaults();
    rst = 1'b1;
    model_reset();
    @(posedge clk);
    #1;
    total++; if (ch_state !== 8'h00) begin bad++; $display("FAIL reset_ch_state got=%h exp=00", ch_state); end
    total++; if ({warning, fault, shutdown} !== 3'b000) begin bad++; $display("FAIL reset_flags got=%b exp=000", {warning, fault, shutdown}); end
    total++; if (first_valid !== 1'b0) begin bad++; $display("FAIL reset_first_valid got=%b exp=0", first_valid); end
    total++; if (first_ch !== 2'd0) begin bad++; $display("FAIL reset_first_ch got=%0d exp=0", first_ch); end
    rst = 1'b0;
    sample[31:0] = 32'h40A0_0001;
    repeat (3) step();
    total++; if (ch_state !== 8'h00) begin bad++; $display("FAIL idle_no_eval got=%h exp=00", ch_state); end
    sample_valid = 1'b1;
    step();
    total++; if (ch_state[1:0] !== 2'd1) begin bad++; $display("FAIL first_eval got=%0d exp=1", ch_state[1:0]); end
    set_defaults();
  endtask

  task automatic test_overrange();
    logic [1:0] exp_st;
    set_defaults();
    do_reset();
    sample[31:0] = 32'h40A0_0001;
    sample_valid = 1'b1;
    for (int e = 1; e <= 7; e++) begin
      step();
      exp_st = (e < 3) ? 2'd1 : (e < 7) ? 2'd2 : 2'd3;
      total++; if (ch_state[1:0] !== exp_st) begin bad++; $display("FAIL ovr_state edge=%0d got=%0d exp=%0d", e, ch_state[1:0], exp_st); end
      total++; if ({warning, fault, shutdown} !== {exp_st == 2'd1, exp_st == 2'd2, exp_st == 2'd3}) begin
        bad++; $display("FAIL ovr_flags edge=%0d got=%b", e, {warning, fault, shutdown});
      end
    end
    total++; if (first_valid !== 1'b1 || first_ch !== 2'd0) begin bad++; $display("FAIL ovr_first got=%b/%0d exp=1/0", first_valid, first_ch); end
    set_defaults();
  endtask

  task automatic test_fp_edges();
    set_defaults();
    do_reset();
    sample[63:32] = 32'hBF80_0000;
    sample_valid  = 1'b1;
    step();
    total++; if (ch_state[3:2] !== 2'd1) begin bad++; $display("FAIL fp_neg_one got=%0d exp=1", ch_state[3:2]); end
    set_defaults();
    do_reset();
    thr_lo[63:32] = 32'h0000_0000;
    sample[63:32] = 32'h8000_0000;
    sample_valid  = 1'b1;
    repeat (2) step();
    total++; if (ch_state[3:2] !== 2'd0 || warning !== 1'b0) begin bad++; $display("FAIL fp_neg_zero got=%0d/%b exp=0/0", ch_state[3:2], warning); end
    set_defaults();
    do_reset();
    sample[63:32] = 32'h7FC0_0000;
    sample_valid  = 1'b1;
    step();
    total++; if (ch_state[3:2] !== 2'd1) begin bad++; $display("FAIL fp_nan got=%0d exp=1", ch_state[3:2]); end
    set_defaults();
  endtask

  task automatic test_simultaneous();
    set_defaults();
    do_reset();
    sample[63:32]   = 32'h40A0_0001;
    sample[127:96]  = 32'h40A0_0001;
    sample_valid    = 1'b1;
    repeat (7) step();
    total++; if (ch_state !== 8'hCC) begin bad++; $display("FAIL sim_states got=%h exp=cc", ch_state); end
    total++; if (first_valid !== 1'b1 || first_ch !== 2'd1) begin bad++; $display("FAIL sim_first got=%b/%0d exp=1/1", first_valid, first_ch); end
    clear = 1'b1;
    step();
    clear = 1'b0;
    total++; if (ch_state !== 8'h00) begin bad++; $display("FAIL sim_clear_states got=%h exp=00", ch_state); end
    total++; if (first_valid !== 1'b0 || shutdown !== 1'b0) begin bad++; $display("FAIL sim_clear_flags got=%b/%b exp=0/0", first_valid, shutdown); end
    set_defaults();
  endtask

  task automatic test_recovery();
    logic [1:0] exp_st;
    set_defaults();
    do_reset();
    sample[95:64] = 32'h40A0_0001;
    sample_valid  = 1'b1;
    repeat (3) step();
    total++; if (ch_state[5:4] !== 2'd2 || fault !== 1'b1) begin bad++; $display("FAIL rec_enter got=%0d/%b exp=2/1", ch_state[5:4], fault); end
    for (int i = 0; i < 16; i++) begin
      repeat ($urandom_range(0, 2)) begin
        sample_valid  = 1'b0;
        sample[95:64] = 32'h7FC0_0000;
        step();
        total++; if (ch_state[5:4] !== 2'd2) begin bad++; $display("FAIL rec_gap i=%0d got=%0d exp=2", i, ch_state[5:4]); end
      end
      sample_valid  = 1'b1;
      sample[95:64] = (i == 7) ? 32'h40A0_0001 : FP_2_0;
      step();
      exp_st = (i == 15) ? 2'd0 : 2'd2;
      total++; if (ch_state[5:4] !== exp_st) begin bad++; $display("FAIL rec_seq i=%0d got=%0d exp=%0d", i, ch_state[5:4], exp_st); end
    end
    set_defaults();
  endtask

  task automatic test_async_reset();
    set_defaults();
    do_reset();
    sample[31:0] = 32'h40A0_0001;
    sample_valid = 1'b1;
    step();
    total++; if (warning !== 1'b1) begin bad++; $display("FAIL ar_warn_pre got=%b exp=1", warning); end
    sample_valid = 1'b0;
    @(posedge clk);
    #3 rst = 1'b1;
    model_reset();
    #1;
    total++; if ({ch_state, warning, fault, shutdown, first_valid} !== 12'h000) begin
      bad++; $display("FAIL ar_warn got=%h exp=000", {ch_state, warning, fault, shutdown, first_valid});
    end
    #2 rst = 1'b0;
    sample_valid = 1'b1;
    #4;
    repeat (7) step();
    total++; if (shutdown !== 1'b1 || first_valid !== 1'b1) begin bad++; $display("FAIL ar_shdn_pre got=%b/%b exp=1/1", shutdown, first_valid); end
    sample_valid = 1'b0;
    @(posedge clk);
    #3 rst = 1'b1;
    model_reset();
    #1;
    total++; if ({ch_state, warning, fault, shutdown, first_valid, first_ch} !== 14'h0) begin
      bad++; $display("FAIL ar_shdn got=%h exp=0", {ch_state, warning, fault, shutdown, first_valid, first_ch});
    end
    #2 rst = 1'b0;
    set_defaults();
  endtask

  task automatic test_disable();
    set_defaults();
    do_reset();
    ch_enable    = 4'b1110;
    sample[31:0] = 32'h40A0_0001;
    sample_valid = 1'b1;
    for (int i = 0; i < 8; i++) begin
      step();
      total++; if (ch_state[1:0] !== 2'd0 || warning !== 1'b0) begin bad++; $display("FAIL dis_ch0 i=%0d got=%0d/%b exp=0/0", i, ch_state[1:0], warning); end
    end
    set_defaults();
  endtask

  task automatic test_random();
    int p;
    p = 30;
    set_defaults();
    do_reset();
    for (int c = 0; c < 3000; c++) begin
      if (c % 64 == 0) begin
        case ($urandom_range(0, 2))
          0: p = 5;
          1: p = 30;
          default: p = 70;
        endcase
      end
      sample_valid = ($urandom_range(0, 3) != 0);
      clear        = ($urandom_range(0, 15) == 0);
      for (int k = 0; k < NCH; k++) begin
        ch_enable[k]       = ($urandom_range(0, 29) != 0);
        sample[32*k +: 32] = (int'($urandom_range(0, 99)) < p) ? rnd_abn() : rnd_norm();
      end
      step();
      total++; if (ch_state !== m_chs()) begin bad++; $display("FAIL rnd_ch_state c=%0d got=%h exp=%h", c, ch_state, m_chs()); end
      total++; if (warning !== m_any(1)) begin bad++; $display("FAIL rnd_warning c=%0d got=%b exp=%b", c, warning, m_any(1)); end
      total++; if (fault !== m_any(2)) begin bad++; $display("FAIL rnd_fault c=%0d got=%b exp=%b", c, fault, m_any(2)); end
      total++; if (shutdown !== m_any(3)) begin bad++; $display("FAIL rnd_shutdown c=%0d got=%b exp=%b", c, shutdown, m_any(3)); end
      total++; if (first_valid !== m_fv) begin bad++; $display("FAIL rnd_first_valid c=%0d got=%b exp=%b", c, first_valid, m_fv); end
      total++; if (first_ch !== 2'(m_first)) begin bad++; $display("FAIL rnd_first_ch c=%0d got=%0d exp=%0d", c, first_ch, m_first); end
    end
    set_defaults();
  endtask

  initial begin
    rst = 1'b1;
    set_defaults();
    test_reset();
    test_overrange();
    test_fp_edges();
    test_simultaneous();
    test_recovery();
    test_async_reset();
    test_disable();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/multi_fault_monitor.md
MULTI_FAULT_MONITOR -- requirements
Module: multi_fault_monitor

Interface
REQ-001 Parameter NCH, default 4, number of monitored channels (legal range 2..16).
REQ-002 Parameter WARN_CNT, default 3, consecutive abnormal samples for WARNING->FAULT.
REQ-003 Parameter SHDN_CNT, default 4, consecutive abnormal samples for FAULT->SHUTDOWN.
REQ-004 Parameter RECOV_CNT, default 8, consecutive normal samples for recovery.
REQ-005 Parameter AUTO_RECOVER, default 0, 1 = SHUTDOWN may self-recover.
REQ-006 Clocking SHALL be one clock, clk; reset rst SHALL be asynchronous and active-high.
REQ-007 Ports: clk input 1 system clock; rst input 1 async active-high reset.
REQ-008 Ports: sample_valid input 1 new sample set present; sample input 32*NCH IEEE-754 fp32 values, channel k at [32k+31:32k].
REQ-009 Ports: thr_hi input 32*NCH fp32 upper limits; thr_lo input 32*NCH fp32 lower limits; ch_enable input NCH per-channel enable; clear input 1 shutdown acknowledge pulse.
REQ-010 Ports: warning, fault, shutdown outputs 1 each, aggregate flags; ch_state output 2*NCH per-channel state; first_ch output clog2(NCH) first-shutdown channel index; first_valid output 1 first_ch holds a valid index.

Function
REQ-011 A channel sample SHALL be abnormal when sample > thr_hi or sample < thr_lo under IEEE-754 ordering; -0 equals +0; any NaN sample is abnormal.
REQ-012 States SHALL be encoded NORMAL=0, WARNING=1, FAULT=2, SHUTDOWN=3; each channel has one state, one saturating bad counter, one saturating good counter.
REQ-013 Evaluation SHALL occur only on edges where sample_valid=1; otherwise state and counters hold.
REQ-014 NORMAL: abnormal -> WARNING, bad=1; normal -> stay.
REQ-015 WARNING: abnormal -> bad+1, on reaching WARN_CNT -> FAULT with bad=0; normal -> NORMAL with bad=0.
REQ-016 FAULT: abnormal -> bad+1, good=0, on reaching SHDN_CNT -> SHUTDOWN; normal -> good+1, on reaching RECOV_CNT -> NORMAL with both counters 0.
REQ-017 SHUTDOWN: sticky; exits to NORMAL on clear; if AUTO_RECOVER=1 also exits after RECOV_CNT consecutive normal samples (abnormal zeroes good).
REQ-018 clear=1 SHALL force every SHUTDOWN channel to NORMAL, zero its counters and clear first_valid; when clear coincides with sample_valid, clear wins and that sample is discarded for those channels.
REQ-019 ch_enable[k]=0 SHALL hold channel k in NORMAL with counters 0, overriding every other condition.
REQ-020 Outputs SHALL be registered: ch_state equals state after the edge; warning/fault/shutdown = OR over channels in WARNING/FAULT/SHUTDOWN respectively, updated in the same edge.
REQ-021 first_ch SHALL latch the lowest-index channel entering SHUTDOWN while first_valid=0; simultaneous entries -> lowest index; held until clear or rst.

Reset
REQ-022 rst=1 SHALL immediately set all channels NORMAL, counters 0, warning=fault=shutdown=0, ch_state=0, first_ch=0, first_valid=0, including mid-sequence.
REQ-023 The first evaluation after rst deasserts SHALL be the first edge with sample_valid=1.

Structure
REQ-024 Package fault_mon_pkg SHALL hold the state enum, fp32 constants FP_5_0=0x40A00000, FP_2_0=0x40000000, FP_0_1=0x3DCCCCCD, and the default parameter values.
REQ-025 Sub-module fp32_cmp (combinational, outputs gt/lt/unordered) SHALL be instantiated 2*NCH times.

Verification
REQ-026 ch0 thr_hi=0x40A00000, sample=0x40A00001 every cycle -> warning after edge 1, fault after edge 3, shutdown after edge 7, first_ch=0.
REQ-027 ch1 thr_lo=0x3DCCCCCD: sample 0xBF800000 -> abnormal; sample 0x80000000 with thr_lo=0x00000000 -> stays NORMAL; sample 0x7FC00000 -> abnormal.
REQ-028 ch1 and ch3 reach SHUTDOWN on the same edge -> first_ch=1, first_valid=1; then clear pulse with abnormal sample -> both NORMAL, first_valid=0.
REQ-029 ch2 in FAULT, 7 normal samples, 1 abnormal, 8 normal -> FAULT until edge 16, NORMAL after it; sample_valid gaps do not alter counts.
REQ-030 rst asserted mid-WARNING and mid-SHUTDOWN, asynchronously between edges -> all outputs 0 immediately; ch_enable[0]=0 with abnormal input -> ch0 stays NORMAL.
